mor1kx_gpr_ctx_seq: RTL

SPR-bus initiator that saves or restores a contiguous range of GPRs through the GPR SPR window (group 0, addresses 0x400-0x5FF), the target side of which is the register file's SPR port. It is used by the context-switch and debug logic. A save reads GPRs and streams them out; a restore consumes a stream and writes the GPRs back. Shadow GPR sets are selected with the address bits above the register index.

---
 rtl/mor1kx_gpr_ctx_pkg.sv | 21 ++
 rtl/mor1kx_spr_timeout_cnt.sv | 28 ++
 rtl/mor1kx_gpr_ctx_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mor1kx_gpr_ctx_pkg.sv
// Shared types and helpers for the GPR context save/restore sequencer.
// Holds the FSM state encoding and the GPR SPR window address compose.
package mor1kx_gpr_ctx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_PUSH = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_FIN     = 3'd5
  } ctx_state_e;

  localparam logic [15:0] SPR_GPR_BASE = 16'h0400;

  // Offset is {shadow set, GPR index}, zero-extended into the 9-bit window.
  function automatic logic [15:0] gpr_spr_addr(input logic [8:0] off);
    return SPR_GPR_BASE + {7'd0, off};
  endfunction

endpackage

// File: rtl/mor1kx_spr_timeout_cnt.sv
// Per-access SPR watchdog: counts un-acked strobe cycles and flags expiry.
// LIMIT of 0 disables expiry entirely.
module mor1kx_spr_timeout_cnt #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] cnt_q;

  assign expire = (LIMIT != 0) && en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !expire) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mor1kx_gpr_ctx_seq.sv
// SPR-bus initiator that saves or restores a contiguous GPR range through
// the GPR SPR window, for context-switch and debug logic.
module mor1kx_gpr_ctx_seq
  import mor1kx_gpr_ctx_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
  parameter int unsigned SET_WIDTH            = 4,
  parameter int unsigned TIMEOUT_CYCLES       = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic                            cmd_save_i,
  input  logic [SET_WIDTH-1:0]            cmd_set_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] cmd_first_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] cmd_last_i,
  output logic                            sv_valid_o,
  input  logic                            sv_ready_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] sv_dat_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] sv_idx_o,
  input  logic                            rs_valid_i,
  output logic                            rs_ready_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rs_dat_i,
  output logic [15:0]                     spr_bus_addr_o,
  output logic                            spr_bus_stb_o,
  output logic                            spr_bus_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
  input  logic                            spr_gpr_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o
);

  localparam int unsigned OW    = OPTION_OPERAND_WIDTH;
  localparam int unsigned AW    = OPTION_RF_ADDR_WIDTH;
  localparam int unsigned OFF_W = SET_WIDTH + AW;

  ctx_state_e           state_q, state_n;
  logic [AW-1:0]        idx_q, idx_n;
  logic [AW-1:0]        last_q, last_n;
  logic [SET_WIDTH-1:0] set_q, set_n;
  logic [OW-1:0]        data_q, data_n;
  logic                 err_q, err_n;

  logic                 stb_q, we_q;
  logic [15:0]          addr_q;
  logic [OW-1:0]        wdat_q;

  logic                 tmo_expire;
  logic                 req_n, req_enter;
  logic [OFF_W-1:0]     req_off;

  mor1kx_spr_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (!stb_q),
    .en     (stb_q && !spr_gpr_ack_i),
    .expire (tmo_expire)
  );

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    last_n  = last_q;
    set_n   = set_q;
    data_n  = data_q;
    err_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          idx_n  = cmd_first_i;
          last_n = cmd_last_i;
          set_n  = cmd_set_i;
          if (cmd_first_i > cmd_last_i) state_n = ST_FIN;
          else if (cmd_save_i)          state_n = ST_RD_REQ;
          else                          state_n = ST_WR_DATA;
        end
      end
      ST_RD_REQ: begin
        if (spr_gpr_ack_i) begin
          data_n  = spr_gpr_dat_i;
          state_n = ST_RD_PUSH;
        end else if (tmo_expire) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_RD_PUSH: begin
        if (sv_ready_i) begin
          if (idx_q == last_q) begin
            state_n = ST_FIN;
          end else begin
            idx_n   = idx_q + AW'(1);
            state_n = ST_RD_REQ;
          end
        end
      end
      ST_WR_DATA: begin
        if (rs_valid_i) begin
          data_n = rs_dat_i;
          // r0 is hardwired: its word is consumed but never written.
          if (idx_q != '0)          state_n = ST_WR_REQ;
          else if (idx_q == last_q) state_n = ST_FIN;
          else                      idx_n   = idx_q + AW'(1);
        end
      end
      ST_WR_REQ: begin
        if (spr_gpr_ack_i) begin
          if (idx_q == last_q) begin
            state_n = ST_FIN;
          end else begin
            idx_n   = idx_q + AW'(1);
            state_n = ST_WR_DATA;
          end
        end else if (tmo_expire) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Bus outputs are registered off the next state, so stb tracks the REQ
  // states exactly and addr/we/dat load only when a new access starts.
  assign req_n     = (state_n == ST_RD_REQ) || (state_n == ST_WR_REQ);
  assign req_enter = req_n && !stb_q;
  assign req_off   = {set_n, idx_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      set_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      last_q  <= last_n;
      set_q   <= set_n;
      data_q  <= data_n;
      err_q   <= err_n;
      stb_q   <= req_n;
      if (req_enter) begin
        addr_q <= gpr_spr_addr(9'(req_off));
        we_q   <= (state_n == ST_WR_REQ);
        if (state_n == ST_WR_REQ) wdat_q <= data_n;
      end
    end
  end

  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_FIN);
  assign err_o          = err_q;
  assign sv_valid_o     = (state_q == ST_RD_PUSH);
  assign sv_dat_o       = data_q;
  assign sv_idx_o       = idx_q;
  assign rs_ready_o     = (state_q == ST_WR_DATA);
  assign spr_bus_stb_o  = stb_q;
  assign spr_bus_we_o   = we_q;
  assign spr_bus_addr_o = addr_q;
  assign spr_bus_dat_o  = wdat_q;

endmodule
